plab4_net_router_output_ctrl: RTL
=================================

# plab4_net_router_output_ctrl

Per-output-port control for the ring router. It collects the one-bit requests from the three router input controls (west, terminal, east), picks one with a round-robin arbiter, and returns a one-hot grant. It also drives the crossbar select and the valid for its output channel. One instance sits downstream of the input controls for each router output port. It consumes their `reqs` bits and produces the `grants` bits they use to form `in_rdy`.

## Interface
Parameters:
- `p_num_reqs`, default 3: number of requesting inputs. Fixed at 3 in this design. Bit 0 is west, bit 1 is terminal, bit 2 is east.

Ports:
- `clk`, input, 1: single clock; all state updates on the posedge.
- `reset`, input, 1: synchronous, active-high.
- `domain`, input, 1, label `{L}`: security domain selector. Every port below is labelled `{Domain domain}`. It has no functional effect on arbitration.
- `reqs`, input, 3: bit i is the request from input i for this output port.
- `grants`, output, 3: one-hot or zero; bit i grants input i.
- `out_val`, output, 1: a message is presented on the output channel this cycle.
- `out_rdy`, input, 1: the downstream channel accepts this cycle.
- `xbar_sel`, output, 2: crossbar select, equal to the index of the granted input.

## Operation
- State: a one-hot priority register `prio[2:0]`; the set bit marks the highest-priority input.
- Winner: the first requesting input found scanning upward from `prio`, wrapping from 2 to 0.
- Grant rule: `grants` = winner when `out_rdy` is 1 and at least one request is set; otherwise `000`. `grants` is never multi-hot.
- `out_val` = `|grants`. This is a requirement: `out_val` must never assert without a grant.
- `xbar_sel` = encode(`grants`): `001` gives 0, `010` gives 1, `100` gives 2. It is 0 when there is no grant.
- Priority update: on a clock edge where `|grants` is 1, `prio` becomes the grant rotated left by one (`001` to `010`, `010` to `100`, `100` to `001`). Otherwise `prio` holds.
- Transfer semantics:
  - A grant is always a completed transfer, because the grant already implies `out_rdy`.
  - Messages are single-flit, so there is no lock or hold across cycles.
- `out_rdy` low: `grants` is `000` and `prio` holds, so there is no starvation from back-pressure.
- A requester that drops `reqs` before being granted is simply not considered; there is no request memory.

## Timing
- `grants`, `out_val` and `xbar_sel` are combinational from `reqs`, `out_rdy` and `prio`, with zero latency. The input control's `in_rdy` is valid in the same cycle.
- `prio` update takes effect on the next posedge; it has one cycle of latency into arbitration.
- Reset:
  - While `reset` is 1, `grants` is `000`, `out_val` is 0 and `xbar_sel` is 0, regardless of `reqs` or `out_rdy`.
  - On the edge where `reset` is sampled high, `prio` becomes `001`.
- Reset asserted mid-stream discards the rotation state. The first post-reset grant follows `prio` = `001`.
- Fairness: with all three inputs requesting continuously and `out_rdy` at 1, each input is granted exactly once in every 3 consecutive cycles.

## Structure
- Sub-module `plab4_net_rr_arb`:
  - Generic round-robin arbiter: `clk`, `reset`, `en`, `reqs` and `grants`, with the `prio` register inside.
  - This block instantiates it with `en` = `out_rdy` and adds the encoder and `out_val`.
- Shared package or header `plab4_net_router_defs`:
  - port index constants `WEST` = 0, `TERM` = 1, `EAST` = 2;
  - select width 2;
  - reset priority `3'b001`.
  - The input control's default pass-through request uses the same constants.

## Test plan
- Reset: assert `reset` with `reqs` = `111` and `out_rdy` = 1. Required: `grants` = `000`, `out_val` = 0, `xbar_sel` = 0. On the first cycle after reset, `grants` = `001`.
- Full contention: `reqs` = `111` and `out_rdy` = 1 for 6 cycles. Required: `grants` = `001`, `010`, `100`, `001`, `010`, `100`, with `xbar_sel` = 0, 1, 2, 0, 1, 2.
- Back-pressure: after a grant of `001`, hold `reqs` = `111` with `out_rdy` = 0 for 3 cycles. Required: `grants` = `000` and `out_val` = 0 throughout. When `out_rdy` returns to 1, `grants` = `010`.
- Sparse requests: after a grant of `001`, apply `reqs` = `100`. Required: `grants` = `100`, `xbar_sel` = 2. Next, apply `reqs` = `011`. Required: `grants` = `001`.
- Reset mid-stream: reach `prio` = `100` (last grant was `010`), then assert `reset` for one cycle with `reqs` = `111`. Required: `grants` = `000` during reset, then `001` the next cycle.
- Idle: `reqs` = `000` and `out_rdy` = 1 for several cycles. Required: `grants` = `000`, and `prio` is unchanged, checked via the next grant order.

Source files
------------

// File: rtl/plab4_net_router_defs_pkg.sv
// Shared definitions for the ring router: port indices, select width,
// reset priority and the small helpers used by the output control.
package plab4_net_router_defs;

  localparam int unsigned NUM_REQS = 3;
  localparam int unsigned SEL_W    = 2;

  typedef enum logic [SEL_W-1:0] {
    WEST = 2'd0,
    TERM = 2'd1,
    EAST = 2'd2
  } port_e;

  localparam logic [NUM_REQS-1:0] RESET_PRIO = 3'b001;

  // Next priority after a grant: the input just past the winner goes first.
  function automatic logic [NUM_REQS-1:0] rotl_grant(input logic [NUM_REQS-1:0] g);
    return {g[NUM_REQS-2:0], g[NUM_REQS-1]};
  endfunction

  // One-hot grant to crossbar select; zero when nothing is granted.
  function automatic logic [SEL_W-1:0] encode_grant(input logic [NUM_REQS-1:0] g);
    logic [SEL_W-1:0] sel;
    sel = '0;
    unique case (g)
      3'b001:  sel = WEST;
      3'b010:  sel = TERM;
      3'b100:  sel = EAST;
      default: sel = '0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/plab4_net_router_output_ctrl_rr_arb.sv
// Generic round-robin arbiter with a one-hot priority register.
import plab4_net_router_defs::*;

module plab4_net_rr_arb #(
  parameter int unsigned p_num_reqs = NUM_REQS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [p_num_reqs-1:0] reqs,
  output logic [p_num_reqs-1:0] grants
);

  logic [p_num_reqs-1:0] prio_q;
  logic [p_num_reqs-1:0] prio_d;
  logic [p_num_reqs-1:0] winner;
  logic                  found;

  // Scan upward from the priority bit, wrapping, and take the first request.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 3; j++) begin
        if (!found && prio_q[2'(j)] && reqs[2'((j + k) % 3)]) begin
          winner[2'((j + k) % 3)] = 1'b1;
          found                   = 1'b1;
        end
      end
    end
  end

  always_comb begin
    grants = '0;
    if (en && !reset) begin
      grants = winner;
    end
  end

  always_comb begin
    prio_d = prio_q;
    if (reset) begin
      prio_d = RESET_PRIO;
    end else if (|grants) begin
      prio_d = rotl_grant(grants);
    end
  end

  always_ff @(posedge clk) begin
    prio_q <= prio_d;
  end

endmodule

// File: rtl/plab4_net_router_output_ctrl.sv
// Output-port control: round-robin grant over west/terminal/east requests,
// crossbar select and output valid, all combinational from prio and inputs.
import plab4_net_router_defs::*;

module plab4_net_router_output_ctrl #(
  parameter int unsigned p_num_reqs = NUM_REQS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  domain,
  input  logic [p_num_reqs-1:0] reqs,
  output logic [p_num_reqs-1:0] grants,
  output logic                  out_val,
  input  logic                  out_rdy,
  output logic [SEL_W-1:0]      xbar_sel
);

  // Security label only; it does not steer arbitration.
  logic domain_unused;
  assign domain_unused = domain;

  plab4_net_rr_arb #(
    .p_num_reqs (p_num_reqs)
  ) u_arb (
    .clk    (clk),
    .reset  (reset),
    .en     (out_rdy),
    .reqs   (reqs),
    .grants (grants)
  );

  // Valid is tied to the grant so it can never assert without one.
  always_comb begin
    out_val  = |grants;
    xbar_sel = encode_grant(grants);
  end

endmodule
